// File: rtl/writeback_select_unit.sv
// Registered write-back select: picks ALU, extended load data or PC+4 and
// presents one write-back beat per instruction, waiting on slow memory loads.
module writeback_select_unit #(
   parameter int DATA_W     = 64,
   parameter int REG_ADDR_W = 5,
   parameter int ZERO_REG   = 31
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     ALU_Result,
   input  logic [DATA_W-1:0]     PC_Plus4,
   input  logic [1:0]            MemtoReg,
   input  logic [1:0]            LoadSize,
   input  logic                  LoadSigned,
   input  logic                  RegWrite_in,
   input  logic [REG_ADDR_W-1:0] Rd_in,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_W-1:0]     ReadData,
   output logic                  wb_valid,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0]     WriteData,
   output logic                  spurious_rsp
);

   localparam int MSB_W = $clog2(DATA_W);
   localparam logic [REG_ADDR_W-1:0] XZR = REG_ADDR_W'(ZERO_REG);

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic                  w_accept;
   logic                  w_isLoad;
   logic                  w_rspTaken;
   logic [DATA_W-1:0]     w_selData;
   logic [MSB_W-1:0]      w_fieldMsb;
   logic                  w_fill;
   logic [DATA_W-1:0]     w_loadExt;

   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_regWriteCap;
   logic [1:0]            r_size;
   logic                  r_signed;
   logic                  r_wbValid;
   logic                  r_regWrite;
   logic [REG_ADDR_W-1:0] r_writeReg;
   logic [DATA_W-1:0]     r_writeData;
   logic                  r_spurious;

   assign in_ready     = (r_state == IDLE);
   assign w_accept     = in_valid && in_ready;
   assign w_isLoad     = (MemtoReg == 2'b01);
   assign w_rspTaken   = (r_state == WAIT_MEM) && mem_rsp_valid;
   assign w_selData    = (MemtoReg == 2'b10) ? PC_Plus4 : ALU_Result;

   assign wb_valid     = r_wbValid;
   assign RegWrite     = r_regWrite;
   assign WriteReg     = r_writeReg;
   assign WriteData    = r_writeData;
   assign spurious_rsp = r_spurious;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:     if (w_accept && w_isLoad) w_nextState = WAIT_MEM;
         WAIT_MEM: if (mem_rsp_valid) w_nextState = IDLE;
         default:  w_nextState = IDLE;
      endcase
   end

   // A 64-bit double on a 32-bit datapath degenerates to a full-width word.
   always_comb begin
      w_fieldMsb = MSB_W'(DATA_W - 1);
      case (r_size)
         2'b00:   w_fieldMsb = MSB_W'(7);
         2'b01:   w_fieldMsb = MSB_W'(15);
         2'b10:   w_fieldMsb = MSB_W'(31);
         default: w_fieldMsb = MSB_W'(DATA_W - 1);
      endcase
      w_fill    = r_signed & ReadData[w_fieldMsb];
      w_loadExt = '0;
      for (int i = 0; i < DATA_W; i++) begin
         w_loadExt[i] = (i <= int'(w_fieldMsb)) ? ReadData[i] : w_fill;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd          <= '0;
         r_regWriteCap <= 1'b0;
         r_size        <= 2'b00;
         r_signed      <= 1'b0;
         r_wbValid     <= 1'b0;
         r_regWrite    <= 1'b0;
         r_writeReg    <= '0;
         r_writeData   <= '0;
         r_spurious    <= 1'b0;
      end else begin
         r_wbValid  <= 1'b0;
         r_regWrite <= 1'b0;
         if ((r_state == IDLE) && mem_rsp_valid) begin
            r_spurious <= 1'b1;
         end
         if (w_accept) begin
            r_rd          <= Rd_in;
            r_regWriteCap <= RegWrite_in;
            r_size        <= LoadSize;
            r_signed      <= LoadSigned;
            if (!w_isLoad) begin
               r_wbValid   <= 1'b1;
               r_regWrite  <= RegWrite_in && (Rd_in != XZR);
               r_writeReg  <= Rd_in;
               r_writeData <= w_selData;
            end
         end else if (w_rspTaken) begin
            r_wbValid   <= 1'b1;
            r_regWrite  <= r_regWriteCap && (r_rd != XZR);
            r_writeReg  <= r_rd;
            r_writeData <= w_loadExt;
         end
      end
   end

endmodule

// File: tb/tb_writeback_select_unit.sv
// Self-checking bench for writeback_select_unit: directed test-plan steps plus
// randomized instructions compared against an arithmetic reference model.
module tb_writeback_select_unit;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] ALU_Result;
   logic [63:0] PC_Plus4;
   logic [1:0]  MemtoReg;
   logic [1:0]  LoadSize;
   logic        LoadSigned;
   logic        RegWrite_in;
   logic [4:0]  Rd_in;
   logic        mem_rsp_valid;
   logic [63:0] ReadData;
   logic        wb_valid;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [63:0] WriteData;
   logic        spurious_rsp;

   logic        inReady32;
   logic        wbValid32;
   logic        regWrite32;
   logic [4:0]  writeReg32;
   logic [31:0] writeData32;
   logic        spurious32;

   int vectors;
   int miscompares;

   writeback_select_unit #(.DATA_W(64), .REG_ADDR_W(5), .ZERO_REG(31)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ALU_Result(ALU_Result), .PC_Plus4(PC_Plus4), .MemtoReg(MemtoReg),
      .LoadSize(LoadSize), .LoadSigned(LoadSigned), .RegWrite_in(RegWrite_in),
      .Rd_in(Rd_in), .mem_rsp_valid(mem_rsp_valid), .ReadData(ReadData),
      .wb_valid(wb_valid), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .WriteData(WriteData), .spurious_rsp(spurious_rsp)
   );

   // Narrow instance shares all stimulus; it exists to exercise the 32-bit extension rules.
   writeback_select_unit #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG(31)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady32),
      .ALU_Result(ALU_Result[31:0]), .PC_Plus4(PC_Plus4[31:0]), .MemtoReg(MemtoReg),
      .LoadSize(LoadSize), .LoadSigned(LoadSigned), .RegWrite_in(RegWrite_in),
      .Rd_in(Rd_in), .mem_rsp_valid(mem_rsp_valid), .ReadData(ReadData[31:0]),
      .wb_valid(wbValid32), .RegWrite(regWrite32), .WriteReg(writeReg32),
      .WriteData(writeData32), .spurious_rsp(spurious32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference extension: mask the field, then OR in all-ones above it if negative.
   function automatic logic [63:0] refExt(input logic [63:0] raw, input logic [1:0] size,
                                          input logic sgn, input int width);
      int          bits;
      logic [63:0] mask;
      logic [63:0] v;
      bits = 8 << size;
      if (bits > width) bits = width;
      mask = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
      v = raw & mask;
      if (sgn && raw[bits-1]) v = v | ~mask;
      if (width == 32) v = v & 64'h0000_0000_FFFF_FFFF;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkBeat(input string tag, input logic expRw, input logic [4:0] expReg,
                            input logic [63:0] expData);
      checkOutput({tag, ".wb_valid"}, {63'd0, wb_valid}, 64'd1);
      checkOutput({tag, ".RegWrite"}, {63'd0, RegWrite}, {63'd0, expRw});
      checkOutput({tag, ".WriteReg"}, {59'd0, WriteReg}, {59'd0, expReg});
      checkOutput({tag, ".WriteData"}, WriteData, expData);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
      checkOutput({tag, ".wb_valid"}, {63'd0, wb_valid}, 64'd0);
      checkOutput({tag, ".RegWrite"}, {63'd0, RegWrite}, 64'd0);
      checkOutput({tag, ".WriteReg"}, {59'd0, WriteReg}, 64'd0);
      checkOutput({tag, ".WriteData"}, WriteData, 64'd0);
      checkOutput({tag, ".spurious"}, {63'd0, spurious_rsp}, 64'd0);
   endtask

   task automatic applyStimulus(input logic [63:0] alu, input logic [63:0] pc, input logic [1:0] m2r,
                                input logic [1:0] size, input logic sgn, input logic rw,
                                input logic [4:0] rd);
      in_valid    = 1'b1;
      ALU_Result  = alu;
      PC_Plus4    = pc;
      MemtoReg    = m2r;
      LoadSize    = size;
      LoadSigned  = sgn;
      RegWrite_in = rw;
      Rd_in       = rd;
   endtask

   task automatic doNonLoad(input string tag, input logic [63:0] alu, input logic [63:0] pc,
                            input logic [1:0] m2r, input logic rw, input logic [4:0] rd);
      logic [63:0] expData;
      expData = (m2r == 2'b10) ? pc : alu;
      applyStimulus(alu, pc, m2r, 2'b00, 1'b0, rw, rd);
      tick();
      in_valid = 1'b0;
      checkBeat(tag, rw && (rd != 5'd31), rd, expData);
      checkOutput({tag, ".ready"}, {63'd0, in_ready}, 64'd1);
      tick();
      checkOutput({tag, ".after"}, {63'd0, wb_valid}, 64'd0);
   endtask

   task automatic doLoad(input string tag, input logic [63:0] raw, input logic [1:0] size,
                         input logic sgn, input logic rw, input logic [4:0] rd, input int delay,
                         input logic [63:0] expData);
      applyStimulus($urandom, $urandom, 2'b01, size, sgn, rw, rd);
      tick();
      in_valid = 1'b0;
      checkOutput({tag, ".busy"}, {63'd0, in_ready}, 64'd0);
      for (int i = 1; i < delay; i++) begin
         tick();
         checkOutput({tag, ".waitReady"}, {63'd0, in_ready}, 64'd0);
         checkOutput({tag, ".waitBeat"}, {63'd0, wb_valid}, 64'd0);
      end
      mem_rsp_valid = 1'b1;
      ReadData      = raw;
      tick();
      mem_rsp_valid = 1'b0;
      checkBeat(tag, rw && (rd != 5'd31), rd, expData);
      checkOutput({tag, ".ready"}, {63'd0, in_ready}, 64'd1);
      checkOutput({tag, ".data32"}, {32'd0, writeData32}, refExt(raw, size, sgn, 32));
      checkOutput({tag, ".beat32"}, {63'd0, wbValid32}, 64'd1);
      tick();
      checkOutput({tag, ".after"}, {63'd0, wb_valid}, 64'd0);
   endtask

   initial begin
      logic [63:0] raw;
      logic [63:0] bbData[4];
      logic [4:0]  bbReg[4];
      logic [1:0]  m2r;
      logic [1:0]  size;
      logic        sgn;
      logic        rw;
      logic [4:0]  rd;
      vectors       = 0;
      miscompares   = 0;
      rst_n         = 1'b0;
      in_valid      = 1'b0;
      ALU_Result    = '0;
      PC_Plus4      = '0;
      MemtoReg      = 2'b00;
      LoadSize      = 2'b00;
      LoadSigned    = 1'b0;
      RegWrite_in   = 1'b0;
      Rd_in         = '0;
      mem_rsp_valid = 1'b0;
      ReadData      = '0;

      tick();
      tick();
      checkResetState("reset");
      rst_n = 1'b1;
      tick();

      doNonLoad("aluOp", 64'h1234, 64'h0, 2'b00, 1'b1, 5'd3);

      doLoad("byteSigned",   64'h0123_4567_89AB_CD80, 2'b00, 1'b1, 1'b1, 5'd4, 3, 64'hFFFF_FFFF_FFFF_FF80);
      doLoad("byteUnsigned", 64'h0123_4567_89AB_CD80, 2'b00, 1'b0, 1'b1, 5'd4, 3, 64'h80);
      doLoad("halfSigned",   64'hAAAA_BBBB_8000_F123, 2'b01, 1'b1, 1'b1, 5'd6, 1, 64'hFFFF_FFFF_FFFF_F123);
      doLoad("wordSigned",   64'hAAAA_BBBB_8000_F123, 2'b10, 1'b1, 1'b1, 5'd7, 2, 64'hFFFF_FFFF_8000_F123);
      doLoad("dblSigned",    64'hAAAA_BBBB_8000_F123, 2'b11, 1'b1, 1'b1, 5'd8, 1, 64'hAAAA_BBBB_8000_F123);
      doLoad("wordUnsigned", 64'hAAAA_BBBB_8000_F123, 2'b10, 1'b0, 1'b0, 5'd9, 1, 64'h0000_0000_8000_F123);

      doNonLoad("blXzr", 64'hDEAD, 64'h104, 2'b10, 1'b1, 5'd31);
      doNonLoad("blX30", 64'hDEAD, 64'h104, 2'b10, 1'b1, 5'd30);
      doNonLoad("reserved11", 64'h5555, 64'h104, 2'b11, 1'b1, 5'd2);

      // Four back-to-back non-loads: each beat appears the cycle after its accept.
      for (int i = 0; i < 4; i++) begin
         bbData[i] = {$urandom, $urandom};
         bbReg[i]  = 5'(i + 10);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(bbData[i], 64'h0, 2'b00, 2'b00, 1'b0, 1'b1, bbReg[i]);
         tick();
         checkOutput("b2b.ready", {63'd0, in_ready}, 64'd1);
         checkBeat("b2b", 1'b1, bbReg[i], bbData[i]);
      end
      in_valid = 1'b0;
      tick();
      checkOutput("b2b.after", {63'd0, wb_valid}, 64'd0);

      // Upstream holds a non-load while the load is pending; it is taken in the load's beat cycle.
      applyStimulus(64'h0, 64'h0, 2'b01, 2'b10, 1'b0, 1'b1, 5'd5);
      tick();
      applyStimulus(64'hBEEF, 64'h0, 2'b00, 2'b00, 1'b0, 1'b1, 5'd7);
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("hold.busy", {63'd0, in_ready}, 64'd0);
         checkOutput("hold.noBeat", {63'd0, wb_valid}, 64'd0);
      end
      mem_rsp_valid = 1'b1;
      ReadData      = 64'h0000_0001_2345_6789;
      tick();
      mem_rsp_valid = 1'b0;
      checkBeat("hold.load", 1'b1, 5'd5, 64'h2345_6789);
      checkOutput("hold.ready", {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      checkBeat("hold.alu", 1'b1, 5'd7, 64'hBEEF);
      tick();
      checkOutput("hold.after", {63'd0, wb_valid}, 64'd0);

      // Randomized instruction mix against the reference model.
      for (int n = 0; n < 24; n++) begin
         rw   = 1'($urandom_range(0, 1));
         rd   = 5'($urandom_range(0, 31));
         size = 2'($urandom_range(0, 3));
         sgn  = 1'($urandom_range(0, 1));
         raw  = {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) begin
            m2r = 2'($urandom_range(0, 2));
            if (m2r == 2'b01) m2r = 2'b11;
            doNonLoad($sformatf("rnd%0d.nonload", n), {$urandom, $urandom}, {$urandom, $urandom},
                      m2r, rw, rd);
         end else begin
            doLoad($sformatf("rnd%0d.load", n), raw, size, sgn, rw, rd,
                   int'($urandom_range(1, 4)), refExt(raw, size, sgn, 64));
         end
      end
      checkOutput("noSpuriousYet", {63'd0, spurious_rsp}, 64'd0);

      mem_rsp_valid = 1'b1;
      ReadData      = 64'hFFFF;
      tick();
      mem_rsp_valid = 1'b0;
      checkOutput("spurious.set", {63'd0, spurious_rsp}, 64'd1);
      checkOutput("spurious.noBeat", {63'd0, wb_valid}, 64'd0);
      checkOutput("spurious.state", {63'd0, in_ready}, 64'd1);
      tick();
      tick();
      checkOutput("spurious.sticky", {63'd0, spurious_rsp}, 64'd1);
      doNonLoad("spurious.stillWorks", 64'h77, 64'h0, 2'b00, 1'b1, 5'd1);
      checkOutput("spurious.sticky2", {63'd0, spurious_rsp}, 64'd1);

      // Reset while a load is pending: outputs clear immediately and the load never completes.
      applyStimulus(64'h0, 64'h0, 2'b01, 2'b11, 1'b0, 1'b1, 5'd12);
      tick();
      in_valid = 1'b0;
      checkOutput("midReset.busy", {63'd0, in_ready}, 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetState("midReset");
      tick();
      rst_n = 1'b1;
      tick();
      mem_rsp_valid = 1'b1;
      ReadData      = 64'h1234_5678;
      tick();
      mem_rsp_valid = 1'b0;
      checkOutput("postReset.noBeat", {63'd0, wb_valid}, 64'd0);
      checkOutput("postReset.spurious", {63'd0, spurious_rsp}, 64'd1);
      tick();
      checkOutput("postReset.noBeat2", {63'd0, wb_valid}, 64'd0);
      checkOutput("postReset.data", WriteData, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
